btle_rx_pdu_reporter: RTL and testbench

- Sits directly downstream of the BLE controller's PHY RX result interface.
- On each decode-end it reads the received PDU octets out of the RX PDU memory through the address/data port.
- It wraps the octets in an HCI-style event frame and streams the frame byte-by-byte, with a valid/ready handshake, into the UART frame transmitter feeding the host.
- It reports drops when a new packet arrives while a report is still in progress.

---
 rtl/btle_hci_pkg.sv | 22 ++
 rtl/btle_rx_pdu_reporter.sv | 174 +++++++++++++++++
 tb/tb_btle_rx_pdu_reporter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btle_hci_pkg.sv
// rtl/btle_hci_pkg.sv - HCI framing constants and reporter FSM states shared by the RX PDU reporter
package btle_hci_pkg;

  localparam logic [7:0] HCI_PKT_EVENT      = 8'h04;
  localparam logic [7:0] HCI_EVT_LE_META    = 8'h3E;
  localparam logic [7:0] HCI_SUBEVT_RAW_PDU = 8'hFF;

  localparam int PDU_HDR_OCTETS   = 2;
  localparam int REPORT_HDR_BYTES = 6;

  localparam int STATUS_CRC_FAIL = 0;
  localparam int STATUS_TRUNC    = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_PDU  = 3'd3,
    ST_DONE = 3'd4
  } rpt_state_e;

endpackage

// File: rtl/btle_rx_pdu_reporter.sv
// rtl/btle_rx_pdu_reporter.sv - wraps each decoded RX PDU in an HCI vendor event and streams it bytewise
module btle_rx_pdu_reporter
  import btle_hci_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH   = 6,
  parameter int MEM_READ_LATENCY = 1,
  parameter bit REPORT_CRC_FAIL  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_decode_end,
  input  logic                      rx_crc_ok,
  input  logic [2:0]                rx_best_phase,
  input  logic [6:0]                rx_payload_length,
  output logic [MEM_ADDR_WIDTH-1:0] rx_pdu_octet_mem_addr,
  input  logic [7:0]                rx_pdu_octet_mem_data,
  output logic [7:0]                byte_data,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      busy,
  output logic                      report_done,
  output logic [7:0]                drop_count
);

  localparam int NW    = MEM_ADDR_WIDTH + 1;
  localparam int MAX_N = 1 << MEM_ADDR_WIDTH;
  localparam int LW    = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;

  rpt_state_e                state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [MEM_ADDR_WIDTH-1:0] k_q, k_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NW-1:0]             n_q, n_d;
  logic [7:0]                status_q, status_d;
  logic [2:0]                phase_q, phase_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [7:0]                byte_data_q, byte_data_d;
  logic                      byte_valid_q, byte_valid_d;
  logic [7:0]                drop_q, drop_d;

  logic [7:0]    len_total;
  logic          trunc_in;
  logic [NW-1:0] n_in;
  logic          reportable;
  logic          handshake;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [NW-1:0] n,
                                          input logic [7:0] status, input logic [2:0] phase);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HCI_PKT_EVENT;
      3'd1:    b = HCI_EVT_LE_META;
      3'd2:    b = 8'(n) + 8'd3;
      3'd3:    b = HCI_SUBEVT_RAW_PDU;
      3'd4:    b = status;
      default: b = {5'd0, phase};
    endcase
    return b;
  endfunction

  assign len_total  = {1'b0, rx_payload_length} + 8'(PDU_HDR_OCTETS);
  assign trunc_in   = {24'd0, len_total} > 32'(MAX_N);
  assign n_in       = trunc_in ? NW'(MAX_N) : NW'(len_total);
  assign reportable = rx_crc_ok | REPORT_CRC_FAIL;
  assign handshake  = byte_valid_q & byte_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    k_d          = k_q;
    addr_d       = addr_q;
    n_d          = n_q;
    status_d     = status_q;
    phase_d      = phase_q;
    lat_d        = lat_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    drop_d       = drop_q;

    // DONE is not IDLE, so a decode_end landing there is a drop too
    if (rx_decode_end && reportable && state_q != ST_IDLE && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (rx_decode_end && reportable) begin
          status_d                  = '0;
          status_d[STATUS_CRC_FAIL] = ~rx_crc_ok;
          status_d[STATUS_TRUNC]    = trunc_in;
          phase_d                   = rx_best_phase;
          n_d                       = n_in;
          idx_d                     = 3'd0;
          byte_data_d               = HCI_PKT_EVENT;
          byte_valid_d              = 1'b1;
          state_d                   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (handshake) begin
          if (idx_q == 3'(REPORT_HDR_BYTES - 1)) begin
            byte_valid_d = 1'b0;
            k_d          = '0;
            addr_d       = '0;
            lat_d        = '0;
            state_d      = ST_RD;
          end else begin
            idx_d       = idx_q + 3'd1;
            byte_data_d = hdr_byte(idx_q + 3'd1, n_q, status_q, phase_q);
          end
        end
      end
      ST_RD: begin
        if (lat_q == LW'(MEM_READ_LATENCY - 1)) begin
          byte_data_d  = rx_pdu_octet_mem_data;
          byte_valid_d = 1'b1;
          state_d      = ST_PDU;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_PDU: begin
        if (handshake) begin
          byte_valid_d = 1'b0;
          if (NW'(k_q) == n_q - NW'(1)) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + MEM_ADDR_WIDTH'(1);
            addr_d  = k_q + MEM_ADDR_WIDTH'(1);
            lat_d   = '0;
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      k_q          <= '0;
      addr_q       <= '0;
      n_q          <= '0;
      status_q     <= '0;
      phase_q      <= '0;
      lat_q        <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      status_q     <= status_d;
      phase_q      <= phase_d;
      lat_q        <= lat_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign rx_pdu_octet_mem_addr = addr_q;
  assign byte_data             = byte_data_q;
  assign byte_valid            = byte_valid_q;
  assign busy                  = (state_q == ST_HDR) || (state_q == ST_RD) || (state_q == ST_PDU);
  assign report_done           = (state_q == ST_DONE);
  assign drop_count            = drop_q;

endmodule

// File: tb/tb_btle_rx_pdu_reporter.sv
// tb/tb_btle_rx_pdu_reporter.sv - scoreboard bench for the RX PDU reporter
module tb_btle_rx_pdu_reporter;

  localparam int LAT = 1;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dec = 1'b0, dec_nr = 1'b0, crc_ok = 1'b1;
  logic [2:0] phase = '0;
  logic [6:0] plen = '0;
  logic [5:0] addr, addr_nr;
  logic [7:0] mdata, mdata_nr;
  logic [7:0] bdata, bdata_nr;
  logic       bvalid, bvalid_nr;
  logic       bready = 1'b0, bready_nr = 1'b1;
  logic       busy, busy_nr, done, done_nr;
  logic [7:0] drop, drop_nr;
  logic [7:0] mem [64];

  exp_t       exp_q[$];
  int         n_checks = 0, n_fail = 0;
  int         ready_mode = 0, hold_cnt = 0, frame_idx = 0;
  bit         stall_armed = 0, done_due = 0, stall_prev = 0;
  logic [7:0] stall_data = '0;

  always #5 clk = ~clk;

  assign mdata    = mem[addr];
  assign mdata_nr = mem[addr_nr];

  btle_rx_pdu_reporter #(.MEM_ADDR_WIDTH(6), .MEM_READ_LATENCY(LAT), .REPORT_CRC_FAIL(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_decode_end(dec), .rx_crc_ok(crc_ok), .rx_best_phase(phase),
    .rx_payload_length(plen), .rx_pdu_octet_mem_addr(addr), .rx_pdu_octet_mem_data(mdata),
    .byte_data(bdata), .byte_valid(bvalid), .byte_ready(bready), .busy(busy),
    .report_done(done), .drop_count(drop)
  );

  btle_rx_pdu_reporter #(.MEM_ADDR_WIDTH(6), .MEM_READ_LATENCY(LAT), .REPORT_CRC_FAIL(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .rx_decode_end(dec_nr), .rx_crc_ok(crc_ok), .rx_best_phase(phase),
    .rx_payload_length(plen), .rx_pdu_octet_mem_addr(addr_nr), .rx_pdu_octet_mem_data(mdata_nr),
    .byte_data(bdata_nr), .byte_valid(bvalid_nr), .byte_ready(bready_nr), .busy(busy_nr),
    .report_done(done_nr), .drop_count(drop_nr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference frame: fixed HCI header, then the first min(len+2,64) memory octets
  task automatic push_frame(input bit crc, input logic [2:0] ph, input int len);
    int         n;
    logic [7:0] hdr [6];
    exp_t       e;
    n = (len + 2 > 64) ? 64 : len + 2;
    hdr[0] = 8'h04;
    hdr[1] = 8'h3E;
    hdr[2] = 8'(n + 3);
    hdr[3] = 8'hFF;
    hdr[4] = {6'd0, (len + 2 > 64), !crc};
    hdr[5] = {5'd0, ph};
    for (int i = 0; i < 6; i++) begin
      e.b = hdr[i]; e.last = 0; exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e.b = mem[i]; e.last = (i == n - 1); exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input bit crc, input logic [2:0] ph, input logic [6:0] len,
                       input bit to_main, input bit to_nr, input bit expect_frame);
    @(posedge clk); #1;
    if (expect_frame) push_frame(crc, ph, int'(len));
    crc_ok = crc; phase = ph; plen = len; dec = to_main; dec_nr = to_nr;
    @(posedge clk); #1;
    dec = 0; dec_nr = 0;
    crc_ok = 1'($urandom); phase = 3'($urandom); plen = 7'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || exp_q.size() != 0 || done_due) && c < budget) begin
      @(posedge clk); #1; c++;
    end
    chk("idle_within_budget", 32'(c < budget), 32'd1);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    if (stall_armed && frame_idx == 7 && bvalid) begin
      hold_cnt = 20; stall_armed = 0;
    end
    if (hold_cnt > 0) begin
      bready = 0; hold_cnt--;
    end else begin
      case (ready_mode)
        0:       bready = 1;
        1:       bready = 1'($urandom_range(0, 1));
        default: bready = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done_due) begin
        chk("report_done_after_last", 32'(done), 32'd1);
        chk("busy_low_after_last", 32'(busy), 32'd0);
        done_due = 0;
      end else if (done) begin
        n_checks++; n_fail++;
        $display("FAIL report_done_unexpected: got 1 expected 0");
      end
      if (stall_prev) begin
        chk("stall_valid_held", 32'(bvalid), 32'd1);
        chk("stall_data_held", 32'(bdata), 32'(stall_data));
      end
      if (bvalid && bready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", bdata);
        end else begin
          e = exp_q.pop_front();
          chk("frame_byte", 32'(bdata), 32'(e.b));
          if (e.last) begin done_due = 1; frame_idx = 0; end
          else frame_idx++;
        end
      end
      stall_prev = bvalid && !bready;
      stall_data = bdata;
    end else begin
      done_due = 0; stall_prev = 0; frame_idx = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  nr_quiet;
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'h10 + i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_valid", 32'(bvalid), 0);
    chk("rst_byte_data", 32'(bdata), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_report_done", 32'(done), 0);
    chk("rst_drop_count", 32'(drop), 0);
    rst = 1;

    // Basic report with exact cycle timing
    ready_mode = 0;
    repeat (2) @(posedge clk);
    pulse(1, 3'd3, 7'd6, 1, 0, 1);
    chk("first_valid_at_T1", 32'(bvalid), 1);
    cyc = 1;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("done_cycle", 32'(cyc), 32'(7 + (LAT + 1) * 8));
    wait_idle(200);
    chk("basic_drop_count", 32'(drop), 0);

    // Backpressure, with a long stall on frame byte 7
    ready_mode = 1; stall_armed = 1;
    pulse(1, 3'd3, 7'd6, 1, 0, 1);
    wait_idle(2000);
    chk("long_stall_applied", 32'(stall_armed), 0);

    // CRC fail: reported by one instance, discarded by the other
    rand_mem();
    pulse(0, 3'd5, 7'd0, 1, 1, 1);
    nr_quiet = 1;
    for (int i = 0; i < 12; i++) begin
      if (bvalid_nr || busy_nr) nr_quiet = 0;
      @(posedge clk); #1;
    end
    chk("nocrc_quiet", 32'(nr_quiet), 1);
    chk("nocrc_drop_count", 32'(drop_nr), 0);
    wait_idle(500);

    pulse(1, 3'd1, 7'd20, 0, 1, 0);
    chk("nocrc_good_busy", 32'(busy_nr), 1);
    pulse(0, 3'd2, 7'd5, 0, 1, 0);
    chk("nocrc_badcrc_not_dropped", 32'(drop_nr), 0);
    pulse(1, 3'd2, 7'd5, 0, 1, 0);
    chk("nocrc_good_dropped", 32'(drop_nr), 1);
    cyc = 0;
    while (busy_nr && cyc < 500) begin @(posedge clk); #1; cyc++; end
    chk("nocrc_frame_ends", 32'(busy_nr), 0);

    // Truncation to 64 PDU octets
    rand_mem();
    pulse(1, 3'($urandom), 7'd100, 1, 0, 1);
    wait_idle(3000);

    // Random packets
    for (int t = 0; t < 8; t++) begin
      rand_mem();
      ready_mode = $urandom_range(0, 1);
      pulse(1'($urandom), 3'($urandom), 7'($urandom_range(0, 127)), 1, 0, 1);
      wait_idle(3000);
    end

    // Drop saturation while stalled
    rand_mem();
    ready_mode = 2;
    pulse(1, 3'd4, 7'd10, 1, 0, 1);
    for (int i = 0; i < 300; i++) pulse(1'($urandom), 3'($urandom), 7'($urandom), 1, 0, 0);
    chk("drop_saturated", 32'(drop), 32'd255);
    chk("busy_while_stalled", 32'(busy), 1);
    ready_mode = 1;
    wait_idle(2000);

    // Reset during PDU byte 3
    rand_mem();
    ready_mode = 0;
    pulse(1, 3'd6, 7'd20, 1, 0, 1);
    cyc = 0;
    while (!(frame_idx == 9 && bvalid) && cyc < 500) begin @(posedge clk); #1; cyc++; end
    chk("reached_pdu_byte3", 32'(cyc < 500), 1);
    rst = 0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_byte_valid", 32'(bvalid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_drop_count", 32'(drop), 0);
    rst = 1;
    pulse(1, 3'd2, 7'd9, 1, 0, 1);
    chk("post_rst_first_byte", 32'(bdata), 32'h04);
    wait_idle(500);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
